// File: rtl/scm16_exec_ctrl.sv
// SCM16 multi-cycle fetch/decode/execute sequencer: owns the PC and steps each instruction
// through FETCH, DECODE, EXEC/MEM and WB, driving the external ROM, register file, ALU/COND and RAM port.
module scm16_exec_ctrl #(
  parameter logic [15:0] PC_RESET     = 16'h0000,
  parameter int          INSTR_STRIDE = 4,
  parameter int          MEM_TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  output logic [15:0] prog_addr_o,
  input  logic [15:0] prog_op_i,
  input  logic [15:0] prog_a1_i,
  input  logic [15:0] prog_a2_i,
  input  logic [15:0] prog_dst_i,
  output logic [2:0]  rf_ra_o,
  output logic [2:0]  rf_rb_o,
  input  logic [15:0] rf_da_i,
  input  logic [15:0] rf_db_i,
  output logic        rf_we_o,
  output logic [2:0]  rf_wa_o,
  output logic [15:0] rf_wd_o,
  output logic        alu_en_o,
  output logic [3:0]  alu_func_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  input  logic [15:0] alu_y_i,
  input  logic        cond_true_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i,
  output logic        halted_o,
  output logic        err_o,
  output logic [15:0] retired_o
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [15:0] STRIDE   = 16'(INSTR_STRIDE);
  localparam logic [7:0]  TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] a1_q, a1_d;
  logic [15:0] a2_q, a2_d;
  logic [3:0]  dst_q, dst_d;
  logic [15:0] res_q, res_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] opa, opb;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_RESET;
      op_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      dst_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      dst_q     <= dst_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  // Result holding register is pure datapath; it is always written before WB reads it.
  always_ff @(posedge clk_i) begin
    res_q <= res_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    dst_d       = dst_q;
    res_d       = res_q;
    tmo_d       = '0;
    err_d       = err_q;
    retired_d   = retired_q;
    opa         = op_q[7] ? a1_q : rf_da_i;
    opb         = op_q[6] ? a2_q : rf_db_i;
    prog_addr_o = pc_q;
    rf_ra_o     = a1_q[2:0];
    rf_rb_o     = a2_q[2:0];
    rf_we_o     = 1'b0;
    rf_wa_o     = '0;
    rf_wd_o     = '0;
    alu_en_o    = 1'b0;
    alu_func_o  = '0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    halted_o    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (run_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = prog_op_i[7:0];
        a1_d    = prog_a1_i;
        a2_d    = prog_a2_i;
        dst_d   = prog_dst_i[3:0];
        rf_ra_o = prog_a1_i[2:0];
        rf_rb_o = prog_a2_i[2:0];
        // ALU and LOAD write a destination, so reject a bad one before any side effect.
        if (prog_op_i == 16'hFFFF) begin
          state_d = S_HALT;
        end else if (!prog_op_i[4] && prog_dst_i[3] && prog_dst_i != 16'h0008) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else if (prog_op_i[5]) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_func_o = op_q[3:0];
        alu_a_o    = opa;
        alu_b_o    = opb;
        if (op_q[5:4] == 2'b00) begin
          alu_en_o = 1'b1;
          res_d    = alu_y_i;
          state_d  = S_WB;
        end else begin
          pc_d      = cond_true_i ? a1_q : pc_q + STRIDE;
          retired_d = retired_q + 16'd1;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = op_q[4];
        mem_addr_o  = opa;
        mem_wdata_o = opb;
        if (mem_ack_i) begin
          if (op_q[4]) begin
            pc_d      = pc_q + STRIDE;
            retired_d = retired_q + 16'd1;
            state_d   = S_FETCH;
          end else begin
            res_d   = mem_rdata_i;
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        if (!dst_q[3]) begin
          rf_we_o = 1'b1;
          rf_wa_o = dst_q[2:0];
          rf_wd_o = res_q;
          pc_d    = pc_q + STRIDE;
        end else begin
          pc_d = res_q;
        end
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign err_o     = err_q;
  assign retired_o = retired_q;

endmodule
